// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg
// Shared types and constants for the UART echo bridge.
//   tx_state_t     : transmit handshake FSM states
//   DEFAULT_DEPTH  : default FIFO depth (entries)
//   DROP_CNT_W     : width of the optional dropped-byte counter
//   sat_inc_drop   : saturating increment for the dropped-byte counter
package uart_echo_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DROP_CNT_W    = 16;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] value);
        logic [DROP_CNT_W-1:0] result;
        if (value == {DROP_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_echo_bridge_byte_fifo.sv
// byte_fifo
// Synchronous byte FIFO with wrap-bit pointers. Pushes into a full FIFO and
// pops from an empty FIFO are ignored. dout always shows the head entry.
// level, full and empty are registered, computed from the next pointers so
// they describe the state after each edge.
// Parameters:
//   DEPTH  : number of entries, power of two, 2..256
//   ADDR_W : derived pointer index width, $clog2(DEPTH)
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   push, din    : write request and data
//   pop          : remove head entry
//   dout         : head entry
//   level        : occupancy 0..DEPTH
//   full, empty  : occupancy flags
module byte_fifo
    import uart_echo_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [7:0]      din,
    output logic [7:0]      dout,
    output logic [ADDR_W:0] level,
    output logic            full,
    output logic            empty
);

    localparam logic [ADDR_W:0] PTR_INC = {{ADDR_W{1'b0}}, 1'b1};

    logic [7:0]      mem_r [DEPTH];
    logic [ADDR_W:0] wr_ptr_r;
    logic [ADDR_W:0] rd_ptr_r;
    logic [ADDR_W:0] level_r;
    logic            full_r;
    logic            empty_r;

    logic            do_push_s;
    logic            do_pop_s;
    logic [ADDR_W:0] wr_ptr_s;
    logic [ADDR_W:0] rd_ptr_s;

    // Qualify requests against registered flags and compute next pointers.
    always_comb begin
        do_push_s = push && !full_r;
        do_pop_s  = pop && !empty_r;
        if (do_push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_INC;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_INC;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
    end

    // Pointer and status registers; status derived from the next pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(ADDR_W+1){1'b0}};
            rd_ptr_r <= {(ADDR_W+1){1'b0}};
            level_r  <= {(ADDR_W+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            level_r  <= wr_ptr_s - rd_ptr_s;
            // Same slot index but different lap bit means the writer is a full lap ahead.
            full_r   <= (wr_ptr_s[ADDR_W-1:0] == rd_ptr_s[ADDR_W-1:0]) &&
                        (wr_ptr_s[ADDR_W] != rd_ptr_s[ADDR_W]);
            empty_r  <= (wr_ptr_s == rd_ptr_s);
        end
    end

    // Storage array; not reset, contents are only meaningful below the level.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r[ADDR_W-1:0]];
    assign level = level_r;
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_echo_bridge.sv
// uart_echo_bridge
// Echo datapath on the host side of the uart block: received bytes are
// queued in a byte_fifo and sent back, in order, through the uart transmit
// handshake. Bytes arriving while the FIFO is full are dropped and flagged.
// Optional feature macro: UART_ECHO_STATS_EN adds the drop_count port and a
// saturating 16-bit dropped-byte counter.
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   rx_ready, rx_byte : one-cycle received-byte strobe and data
//   tx_busy           : uart transmitter busy
//   tx_req, tx_byte   : one-cycle send request and byte (held through the frame)
//   fifo_level        : FIFO occupancy 0..DEPTH
//   fifo_empty        : FIFO empty flag
//   fifo_full         : FIFO full flag
//   overflow          : sticky, set on the first dropped byte
//   drop_count        : dropped-byte count (UART_ECHO_STATS_EN only)
module uart_echo_bridge
    import uart_echo_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_byte,
    input  logic                  tx_busy,
    output logic                  tx_req,
    output logic [7:0]            tx_byte,
    output logic [ADDR_W:0]       fifo_level,
    output logic                  fifo_empty,
    output logic                  fifo_full,
`ifdef UART_ECHO_STATS_EN
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
`else
    output logic                  overflow
`endif
);

    tx_state_t  state_r;
    tx_state_t  state_s;
    logic       tx_req_r;
    logic       tx_req_s;
    logic [7:0] tx_byte_r;
    logic [7:0] tx_byte_s;
    logic       pop_s;
    logic       drop_s;
    logic       overflow_r;
    logic [7:0] head_s;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_ready),
        .pop   (pop_s),
        .din   (rx_byte),
        .dout  (head_s),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Fullness is the registered flag, so a same-cycle pop never rescues a byte.
    assign drop_s = rx_ready && fifo_full;

    // TX FSM next state, pop strobe and next request/byte values.
    always_comb begin
        state_s   = state_r;
        tx_req_s  = 1'b0;
        tx_byte_s = tx_byte_r;
        pop_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // tx_busy guard keeps a request from ever overlapping a frame.
                if (!fifo_empty && !tx_busy) begin
                    tx_byte_s = head_s;
                    pop_s     = 1'b1;
                    tx_req_s  = 1'b1;
                    state_s   = REQ;
                end else begin
                    state_s   = IDLE;
                end
            end
            REQ: begin
                state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // uart raises tx_busy one cycle after sampling the request.
                if (tx_busy) begin
                    state_s = WAIT_DONE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // TX FSM state and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            tx_req_r  <= 1'b0;
            tx_byte_r <= 8'h00;
        end else begin
            state_r   <= state_s;
            tx_req_r  <= tx_req_s;
            tx_byte_r <= tx_byte_s;
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

`ifdef UART_ECHO_STATS_EN
    logic [DROP_CNT_W-1:0] drop_count_r;

    // Saturating count of dropped bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s) begin
            drop_count_r <= sat_inc_drop(drop_count_r);
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign drop_count = drop_count_r;
`endif

    assign tx_req   = tx_req_r;
    assign tx_byte  = tx_byte_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_echo_bridge.sv
// tb_uart_echo_bridge
// Scoreboard bench: stimulus pushes each byte expected to be echoed into a
// queue; a monitor pops and compares on every tx_req. A small uart model
// answers requests with a tx_busy frame; 'hold' forces tx_busy high to stall.
module tb_uart_echo_bridge;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_ready;
    logic [7:0]        rx_byte;
    logic              tx_busy;
    logic              tx_req;
    logic [7:0]        tx_byte;
    logic [ADDR_W:0]   fifo_level;
    logic              fifo_empty;
    logic              fifo_full;
    logic              overflow;
`ifdef UART_ECHO_STATS_EN
    logic [15:0]       drop_count;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    logic busy_m    = 1'b0;
    logic hold      = 1'b0;
    logic pending   = 1'b0;
    int   busy_cnt  = 0;
    int   frame_len = 10;

    assign tx_busy = busy_m | hold;

    always #5 clk = ~clk;

    uart_echo_bridge #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_ready   (rx_ready),
        .rx_byte    (rx_byte),
        .tx_busy    (tx_busy),
        .tx_req     (tx_req),
        .tx_byte    (tx_byte),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
`ifdef UART_ECHO_STATS_EN
        .overflow   (overflow),
        .drop_count (drop_count)
`else
        .overflow   (overflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // uart model: busy rises one cycle after the request is seen, lasts frame_len cycles.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            busy_m   = 1'b0;
            pending  = 1'b0;
            busy_cnt = 0;
        end else begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) busy_m = 1'b0;
            end else if (pending) begin
                pending  = 1'b0;
                busy_m   = 1'b1;
                busy_cnt = frame_len;
            end
            if (tx_req) pending = 1'b1;
        end
    end

    // Monitor: scoreboard compare on tx_req plus handshake rules.
    initial begin
        logic       prev_req;
        logic [7:0] sent_byte;
        logic [7:0] e;
        prev_req  = 1'b0;
        sent_byte = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_req = 1'b0;
            end else begin
                if (tx_req) begin
                    check("req_back_to_back", prev_req, 0);
                    check("req_while_busy", tx_busy, 0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_tx_req: got byte 0x%0h, expected no request at %0t", tx_byte, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte_order", tx_byte, e);
                    end
                    sent_byte = tx_byte;
                end else if (busy_m) begin
                    check("tx_byte_stable", tx_byte, sent_byte);
                end
                prev_req = tx_req;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit kept);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_byte  = b;
        if (kept) exp_q.push_back(b);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        int quiet;
        i     = 0;
        quiet = 0;
        while (i < budget && quiet < 4) begin
            @(posedge clk);
            #1;
            i++;
            if (exp_q.size() == 0 && !tx_busy && !tx_req && fifo_empty && !pending) quiet++;
            else quiet = 0;
        end
        check({name, "_drained"}, (quiet >= 4), 1);
        check({name, "_level0"}, fifo_level, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_req", tx_req, 0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_level", fifo_level, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
`ifdef UART_ECHO_STATS_EN
        check("rst_drop_count", drop_count, 0);
`endif
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Single byte: tx_req one cycle after the write edge.
        frame_len = 100;
        push_byte(8'hA5, 1'b1);
        check("single_level_after_write", fifo_level, 1);
        check("single_empty_after_write", fifo_empty, 0);
        check("single_req_not_yet", tx_req, 0);
        @(posedge clk);
        #1;
        check("single_req_high", tx_req, 1);
        check("single_tx_byte", tx_byte, 8'hA5);
        drain("single", 400);

        // Burst while tx_busy held high, then ordered release.
        frame_len = 10;
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b1);
        check("burst_level5", fifo_level, 5);
        @(negedge clk);
        hold = 1'b0;
        drain("burst", 300);

        // Overflow: 18 pushes into 16 entries, last two dropped.
        hold = 1'b1;
        for (int i = 0; i < 18; i++) push_byte(8'(8'h40 + i), (i < 16));
        check("ovf_full", fifo_full, 1);
        check("ovf_flag", overflow, 1);
        check("ovf_level", fifo_level, 16);
`ifdef UART_ECHO_STATS_EN
        check("ovf_drop_count", drop_count, 2);
`endif
        @(negedge clk);
        hold = 1'b0;
        drain("ovf", 600);

        // Push aligned with an IDLE pop at level 3.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(8'(8'h61 + i), 1'b1);
        check("pp_level3", fifo_level, 3);
        @(negedge clk);
        hold     = 1'b0;
        rx_ready = 1'b1;
        rx_byte  = 8'h64;
        exp_q.push_back(8'h64);
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("pp_level_unchanged", fifo_level, 3);
        check("pp_req", tx_req, 1);
        drain("pp", 300);

        // Push while full with a concurrent pop: byte dropped, level 15.
        hold = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i), 1'b1);
        check("ppf_full", fifo_full, 1);
        @(negedge clk);
        hold     = 1'b0;
        rx_ready = 1'b1;
        rx_byte  = 8'hEE;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        check("ppf_level15", fifo_level, 15);
        check("ppf_not_full", fifo_full, 0);
        check("ppf_req", tx_req, 1);
`ifdef UART_ECHO_STATS_EN
        check("ppf_drop_count", drop_count, 3);
`endif
        drain("ppf", 600);

        // Pointer wrap: 40 bytes at roughly one per frame.
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i * 7 + 3), 1'b1);
            repeat (frame_len + 4) @(posedge clk);
        end
        drain("wrap", 300);
        check("wrap_overflow_sticky", overflow, 1);

        // Reset during WAIT_DONE with level 4.
        frame_len = 100;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i), 1'b1);
        @(negedge clk);
        hold = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_level4", fifo_level, 4);
        check("mid_busy", tx_busy, 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_tx_req", tx_req, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_tx_byte", tx_byte, 8'h00);
`ifdef UART_ECHO_STATS_EN
        check("mid_rst_drop_count", drop_count, 0);
`endif
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        frame_len = 10;
        push_byte(8'h3C, 1'b1);
        @(posedge clk);
        #1;
        check("post_rst_req", tx_req, 1);
        drain("post_rst", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_echo_bridge.md
# uart_echo_bridge

Byte-level client of the `uart` block, sitting on its host side. It consumes received bytes (`rx_ready`/`rx_byte`), buffers them in a synchronous FIFO, and drives the UART transmit handshake (`tx_req`/`tx_byte`/`tx_busy`) to send each byte back in order. It forms the echo datapath of the top level and absorbs bursts while the transmitter is busy.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, 2..256.
- `ADDR_W`, $clog2(DEPTH): pointer width; derived, not overridden.
- `clk` in 1: system clock, the same clock as `uart`.
- `reset` in 1: asynchronous, active-high reset.
- `rx_ready` in 1: one-cycle pulse from `uart`; `rx_byte` is valid in that cycle.
- `rx_byte` in 8: received byte.
- `tx_busy` in 1: from `uart`; high while a frame is being sent.
- `tx_req` out 1: one-cycle send request to `uart`.
- `tx_byte` out 8: byte to send; held stable from `tx_req` until `tx_busy` falls.
- `fifo_level` out ADDR_W+1: current occupancy, 0..DEPTH.
- `fifo_empty` out 1: high when `fifo_level` is 0.
- `fifo_full` out 1: high when `fifo_level` equals DEPTH.
- `overflow` out 1: sticky; set on the first dropped byte, cleared only by reset.
- `drop_count` out 16: only present with `UART_ECHO_STATS_EN`; count of dropped bytes.

## Operation
- **FIFO:** read and write pointers are ADDR_W+1 bits wide and wrap naturally. Full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
- **Push:** when `rx_ready` is high and `fifo_full` is low (registered value), write `rx_byte` at the write pointer and increment it.
- **Drop:** `rx_ready` while `fifo_full` is high drops the byte and sets `overflow`. This holds even if a pop happens in the same cycle; fullness is judged on registered state.
- **Push and pop in the same cycle:** both occur and `fifo_level` is unchanged. A push into an empty FIFO cannot be popped in the same cycle.
- **TX FSM states:**
  - IDLE: if `fifo_empty` is low, load `tx_byte` from the FIFO head, pop, set `tx_req` to 1, and go to REQ.
  - REQ: set `tx_req` to 0 and go to WAIT_BUSY.
  - WAIT_BUSY: when `tx_busy` is 1, go to WAIT_DONE. This state is required because `uart` raises `tx_busy` one cycle after it samples the request; re-requesting too early would be ignored or would duplicate the byte.
  - WAIT_DONE: when `tx_busy` is 0, go to IDLE.
- **`tx_req`:** never high for two consecutive cycles, and never asserted while `tx_busy` is high.
- **`tx_byte`:** changes only on the IDLE to REQ transition.
- **Reset values:** `tx_req`=0, `tx_byte`=8'h00, `fifo_level`=0, `fifo_empty`=1, `fifo_full`=0, `overflow`=0, `drop_count`=0, FSM=IDLE, both pointers 0. FIFO storage is not reset.
- **Reset mid-frame:** everything returns to the reset state immediately and `tx_req` drops asynchronously. `uart` shares the same reset, so no stale handshake survives.

## Timing
- The FIFO write is committed at the edge that samples `rx_ready`. `fifo_empty` and `fifo_level` update after that same edge.
- Into an empty FIFO with the FSM in IDLE: `tx_req` rises at the edge after the write edge. That is one cycle from `rx_ready` sampled to `tx_req` high.
- `tx_req` is high for exactly one cycle.
- Back-to-back bytes: the next `tx_req` comes no earlier than one cycle after `tx_busy` is seen low.
- Pop throughput: one byte per UART frame.

## Configuration
- **`UART_ECHO_STATS_EN` defined:** the `drop_count` port and a 16-bit counter exist. The counter increments on every dropped byte and saturates at 16'hFFFF.
- **`UART_ECHO_STATS_EN` undefined:** no port and no counter. `overflow` is still present. All other behaviour is identical.

## Structure
- **Package `uart_echo_pkg`:**
  - TX FSM state enum: IDLE, REQ, WAIT_BUSY, WAIT_DONE.
  - Default depth constant, 16.
  - Drop counter width, 16.
- **Sub-module `byte_fifo`:** synchronous FIFO with parameter DEPTH and ports push/pop/din/dout/level/full/empty. It is reusable on the TX side of other blocks.
- **`uart_echo_bridge`:** instantiates `byte_fifo` and contains the TX FSM, the overflow flag, and the optional stats counter.

## Test plan
- **Single byte:** after reset, pulse `rx_ready` with 8'hA5. Expect `tx_req` high one cycle later with `tx_byte`=8'hA5. Model `tx_busy` rising next cycle for 100 cycles. Expect no further `tx_req` and `fifo_level` returning to 0.
- **Burst ordering:** 5 `rx_ready` pulses with 8'h01..8'h05 while `tx_busy` is held high. Expect `fifo_level`=5, then sends in order 01..05, one `tx_req` per busy-low interval.
- **Overflow:** with DEPTH=16, push 18 bytes while transmission is stalled. Expect `fifo_full`=1, `overflow`=1, `drop_count`=2 (stats enabled), and bytes 0..15 transmitted intact.
- **Simultaneous push/pop:** at level 3, align `rx_ready` with an IDLE pop. Expect `fifo_level` to stay at 3. Also push while full with a concurrent pop: the byte is dropped and `fifo_level` becomes 15.
- **Pointer wrap:** stream 40 bytes through a DEPTH=16 FIFO at one per frame. Expect exact in-order output across pointer wrap-around.
- **Reset mid-operation:** assert `reset` during WAIT_DONE with level 4. Expect `tx_req`=0, `fifo_level`=0, `overflow`=0 immediately, and a clean echo of the next byte after release.
